// File: rtl/sdma_sap_padding_scanner.sv
// sdma_sap_padding_scanner: walks the padded / zero-inserted output volume in one of six axis orders,
// emitting one valid/ready beat per element with pad flag, source coordinate and last marker.
module sdma_sap_padding_scanner #(
    parameter int DW = 16,
    parameter int PW = 4,
    parameter int ZW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_paddingen,
    input  logic          i_upsampleen,
    input  logic [PW-1:0] i_padl0,
    input  logic [PW-1:0] i_padr0,
    input  logic [PW-1:0] i_padl1,
    input  logic [PW-1:0] i_padr1,
    input  logic [ZW-1:0] i_insz0,
    input  logic [ZW-1:0] i_insz1,
    input  logic [DW-1:0] i_srcfmsc,
    input  logic [DW-1:0] i_srcfmsx,
    input  logic [DW-1:0] i_srcfmsy,
    input  logic [2:0]    i_axis,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_pad,
    output logic [DW-1:0] o_src_c,
    output logic [DW-1:0] o_src_x,
    output logic [DW-1:0] o_src_y,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_done
);
    localparam int LW = DW + ZW + 2;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel0_q, sel0_d, sel1_q, sel1_d;
    logic [DW-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [PW-1:0] pl0_q, pl0_d, pr0_q, pr0_d, pl1_q, pl1_d, pr1_q, pr1_d;
    logic [ZW-1:0] z0_q, z0_d, z1_q, z1_d, ph0_q, ph0_d, ph1_q, ph1_d;
    logic [LW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [DW-1:0] i0_q, i0_d, i1_q, i1_d;
    logic          valid_q, valid_d, pad_q, pad_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic [DW-1:0] c_q, c_d, x_q, x_d, y_q, y_d;

    logic [LW-1:0] sp0, sp1, e0, e1, l0, l1, l2, n_p0, n_p1, n_p2;
    logic [ZW-1:0] n_ph0, n_ph1;
    logic [DW-1:0] n_i0, n_i1;
    logic [5:0]    ord;
    logic          load, w0, w1, src0, src1, nsrc0, nsrc1, empty, upd, npad;

    // Returns {outer, middle, inner} selectors, each 0=c 1=x 2=y.
    function automatic logic [5:0] axis_ord(input logic [2:0] a);
        case (a)
            3'b111:  return {2'd0, 2'd1, 2'd2};
            3'b001:  return {2'd2, 2'd1, 2'd0};
            3'b110:  return {2'd2, 2'd0, 2'd1};
            3'b010:  return {2'd1, 2'd2, 2'd0};
            3'b101:  return {2'd1, 2'd0, 2'd2};
            default: return {2'd0, 2'd2, 2'd1};
        endcase
    endfunction

    function automatic logic [DW-1:0] dim_of(input logic [1:0] s, input logic [DW-1:0] c, x, y);
        return s == 2'd0 ? c : s == 2'd1 ? x : y;
    endfunction

    // Geometry and the step to the next position; in LOAD the step lands on the origin.
    always_comb begin
        sp0   = (s0_q == '0) ? '0 : LW'(s0_q) + (LW'(s0_q) - LW'(1)) * LW'(z0_q);
        sp1   = (s1_q == '0) ? '0 : LW'(s1_q) + (LW'(s1_q) - LW'(1)) * LW'(z1_q);
        e0    = LW'(pl0_q) + sp0;
        e1    = LW'(pl1_q) + sp1;
        l0    = e0 + LW'(pr0_q);
        l1    = e1 + LW'(pr1_q);
        l2    = LW'(s2_q);
        load  = state_q == LOAD;
        w0    = p0_q == l0 - LW'(1);
        w1    = p1_q == l1 - LW'(1);
        src0  = p0_q >= LW'(pl0_q) && p0_q < e0 && ph0_q == '0;
        src1  = p1_q >= LW'(pl1_q) && p1_q < e1 && ph1_q == '0;
        n_p0  = (load || w0) ? '0 : p0_q + LW'(1);
        n_ph0 = (load || n_p0 <= LW'(pl0_q) || ph0_q == z0_q) ? '0 : ph0_q + ZW'(1);
        n_i0  = (load || w0) ? '0 : i0_q + DW'(src0);
        n_p1  = (load || (w0 && w1)) ? '0 : w0 ? p1_q + LW'(1) : p1_q;
        n_ph1 = load ? '0 : !w0 ? ph1_q : (n_p1 <= LW'(pl1_q) || ph1_q == z1_q) ? '0 : ph1_q + ZW'(1);
        n_i1  = (load || (w0 && w1)) ? '0 : i1_q + DW'(w0 && src1);
        n_p2  = load ? '0 : (w0 && w1) ? p2_q + LW'(1) : p2_q;
        nsrc0 = n_p0 >= LW'(pl0_q) && n_p0 < e0 && n_ph0 == '0;
        nsrc1 = n_p1 >= LW'(pl1_q) && n_p1 < e1 && n_ph1 == '0;
        npad  = !(nsrc0 && nsrc1);
    end

    always_comb begin
        ord     = axis_ord(i_axis);
        state_d = state_q;
        sel0_d  = sel0_q;
        sel1_d  = sel1_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        pl0_d   = pl0_q;
        pr0_d   = pr0_q;
        pl1_d   = pl1_q;
        pr1_d   = pr1_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        ph0_d   = ph0_q;
        ph1_d   = ph1_q;
        i0_d    = i0_q;
        i1_d    = i1_q;
        valid_d = valid_q;
        pad_d   = pad_q;
        last_d  = last_q;
        c_d     = c_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        empty   = s0_q == '0 || s1_q == '0 || s2_q == '0;
        upd     = (load && !empty) || (state_q == RUN && i_ready && !last_q);
        if (state_q == IDLE && i_start && !done_q) begin
            state_d = LOAD;
            sel0_d  = ord[1:0];
            sel1_d  = ord[3:2];
            s0_d    = dim_of(ord[1:0], i_srcfmsc, i_srcfmsx, i_srcfmsy);
            s1_d    = dim_of(ord[3:2], i_srcfmsc, i_srcfmsx, i_srcfmsy);
            s2_d    = dim_of(ord[5:4], i_srcfmsc, i_srcfmsx, i_srcfmsy);
            pl0_d   = i_paddingen ? i_padl0 : '0;
            pr0_d   = i_paddingen ? i_padr0 : '0;
            pl1_d   = i_paddingen ? i_padl1 : '0;
            pr1_d   = i_paddingen ? i_padr1 : '0;
            z0_d    = i_upsampleen ? i_insz0 : '0;
            z1_d    = i_upsampleen ? i_insz1 : '0;
        end
        if (load) begin
            state_d = empty ? IDLE : RUN;
            done_d  = empty;
        end
        if (state_q == RUN && i_ready && last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            pad_d   = 1'b0;
            last_d  = 1'b0;
            c_d     = '0;
            x_d     = '0;
            y_d     = '0;
        end
        if (upd) begin
            p0_d    = n_p0;
            p1_d    = n_p1;
            p2_d    = n_p2;
            ph0_d   = n_ph0;
            ph1_d   = n_ph1;
            i0_d    = n_i0;
            i1_d    = n_i1;
            valid_d = 1'b1;
            pad_d   = npad;
            last_d  = n_p0 == l0 - LW'(1) && n_p1 == l1 - LW'(1) && n_p2 == l2 - LW'(1);
            c_d     = npad ? '0 : sel0_q == 2'd0 ? n_i0 : sel1_q == 2'd0 ? n_i1 : DW'(n_p2);
            x_d     = npad ? '0 : sel0_q == 2'd1 ? n_i0 : sel1_q == 2'd1 ? n_i1 : DW'(n_p2);
            y_d     = npad ? '0 : sel0_q == 2'd2 ? n_i0 : sel1_q == 2'd2 ? n_i1 : DW'(n_p2);
        end
        busy_d = state_d != IDLE || done_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel0_q  <= '0;
            sel1_q  <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            pl0_q   <= '0;
            pr0_q   <= '0;
            pl1_q   <= '0;
            pr1_q   <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            ph0_q   <= '0;
            ph1_q   <= '0;
            i0_q    <= '0;
            i1_q    <= '0;
            valid_q <= 1'b0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pl0_q   <= pl0_d;
            pr0_q   <= pr0_d;
            pl1_q   <= pl1_d;
            pr1_q   <= pr1_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            ph0_q   <= ph0_d;
            ph1_q   <= ph1_d;
            i0_q    <= i0_d;
            i1_q    <= i1_d;
            valid_q <= valid_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pad   = pad_q;
    assign o_src_c = c_q;
    assign o_src_x = x_q;
    assign o_src_y = y_q;
    assign o_last  = last_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
endmodule

// File: doc/sdma_sap_padding_scanner.md
# sdma_sap_padding_scanner

Sequential successor to the combinational SAP padding indicator. It owns the destination feature-map scan and walks the padded and optionally zero-inserted (upsampled) output volume in any of the six axis orders. For every output element it emits one beat on a valid/ready stream carrying a padding flag, the source coordinate for real elements, and a last marker. It sits between the SAP instruction decoder and the source-fetch/write-back path, so downstream logic no longer needs its own c/x/y counters.

## Interface
- DW, 16, width of source dimensions and source coordinates
- PW, 4, width of each padding amount
- ZW, 3, width of the per-gap zero-insert count
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle request to start a scan; sampled only in IDLE
- i_paddingen  in  1  enables padding; when 0 all four pad amounts are treated as 0
- i_upsampleen  in  1  enables zero insertion; when 0 the zero-insert count is treated as 0
- i_padl0, i_padr0  in  PW  leading/trailing padding on the inner axis
- i_padl1, i_padr1  in  PW  leading/trailing padding on the middle axis
- i_insz0, i_insz1  in  ZW  zeros inserted between adjacent source elements on the inner and middle axes
- i_srcfmsc, i_srcfmsx, i_srcfmsy  in  DW each  source dimensions
- i_axis  in  3  axis order, given as inner/middle/outer: 000 x/y/c, 111 y/x/c, 001 c/x/y, 110 x/c/y, 010 c/y/x, 101 y/c/x; any other code behaves as 000
- o_valid  out  1  beat valid
- i_ready  in  1  downstream accepts the beat
- o_pad  out  1  the beat is a padding or inserted-zero element
- o_src_c, o_src_x, o_src_y  out  DW each  source coordinate; 0 when o_pad=1
- o_last  out  1  final beat of the scan
- o_busy  out  1  a scan is in progress
- o_done  out  1  one-cycle completion pulse

## Operation
- The block has three states: IDLE, LOAD and RUN.
- IDLE -> LOAD when i_start=1. All inputs are latched at this transition; later input changes have no effect on the scan in progress.
- In LOAD, the block computes the padded length of each axis as L = padl + padr + S + (S-1)*z, where S is that axis's source dimension.
  - The outer axis is never padded or upsampled, so L2 = S2.
  - Arithmetic uses LW = DW+ZW+2 bits and never wraps.
- LOAD -> IDLE with o_done pulsed if any source dimension is 0. No beats are emitted in this case.
- Otherwise LOAD -> RUN. Position counters p0, p1 and p2 are cleared.
- Traversal runs p0 fastest, then p1, then p2.
- For each of the inner and middle axes, a position is a source element only when both hold:
  - padl <= p < padl + S + (S-1)*z
  - the phase counter equals 0
- The phase counter cycles 0..z. It resets to 0 when p == padl and advances on every step inside that span. No modulo or divider hardware is used.
- A source index per axis increments on every source element and clears on axis wrap.
- o_pad = NOT(src0 AND src1).
- When o_pad=0, the o_src_* outputs carry the source indices, mapped back to c/x/y through i_axis.
- o_last = (p0==L0-1) AND (p1==L1-1) AND (p2==L2-1).
- RUN -> IDLE when the last beat is accepted; o_done pulses one cycle after that handshake.
- i_start is ignored while o_busy=1.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted mid-scan aborts immediately. No o_done is produced, and the next scan requires a new i_start.
- Latency:
  - i_start is sampled high at edge t.
  - LOAD occupies cycle t+1.
  - The first o_valid is high at t+2.
- o_busy is high from t+1 through the cycle in which o_done is high.
- Outputs are registered. With i_ready held at 1, throughput is one beat per cycle and there are no bubbles inside a scan, including across axis wrap.
- Handshake rules:
  - A beat transfers on o_valid AND i_ready.
  - While i_ready=0, o_valid, o_pad, o_src_* and o_last are held stable.
  - o_valid never drops without a transfer.
- The total beat count is L0*L1*L2, and exactly one beat carries o_last=1.

## Test plan
- Plain padding:
  - Setup: axis 000, c=1 x=3 y=2, padl0/padr0=1/1, padl1/padr1=1/0, no upsample, ready=1.
  - Required: 15 beats. Row 0 is all pad. Rows 1-2 are P,S,S,S,P with src_x 0,1,2. o_last on beat 15, o_done one cycle later.
- Upsampling:
  - Setup: axis 000, x=3 y=1 c=1, upsample insz0=1, no padding.
  - Required: 5 beats S,P,S,P,S with src_x 0,1,2.
  - Repeat with i_upsampleen=0 and insz0=3: required 3 source beats.
- Axis order:
  - Setup: axis 001, c=2 x=2 y=2, padl0=1, paddingen=1.
  - Required: the inner axis walks c. Each row is P,(c0),(c1). Total 3*2*2=12 beats, and 8 beats carry o_pad=0.
  - Repeat with axis 011: required behaviour identical to 000.
- Backpressure:
  - Setup: case 1 with random i_ready.
  - Required: the beat sequence is identical to the ready=1 run, and outputs are stable during every stall cycle.
- Degenerate and overlap cases:
  - y=0: required o_done at t+2 and no o_valid.
  - i_start during RUN: required to be ignored, with the beat count unchanged.
- Reset mid-scan:
  - Setup: assert i_rst after 5 beats.
  - Required: all outputs 0, no o_done.
  - A fresh i_start must replay the full sequence from beat 1.
